// File: rtl/hex_scan_display_if.sv
// Value/load/blank inputs and multiplexed 7-segment outputs of hex_scan_display.
// The master side feeds values in; the slave side is the display driver.
interface hex_scan_display_if;
  logic [15:0] i_value;
  logic        i_load;
  logic        i_blank;
  logic [3:0]  o_anode;
  logic [6:0]  o_seg;
  logic        o_frame;

  modport master (
    output i_value, i_load, i_blank,
    input  o_anode, o_seg, o_frame
  );

  modport slave (
    input  i_value, i_load, i_blank,
    output o_anode, o_seg, o_frame
  );
endinterface

// File: rtl/hex_scan_display.sv
// Four-digit hex scanner for a common-anode 7-segment display; the shown value
// is swapped only at frame wrap. Optional macro HEX_LZ_BLANK_EN darkens leading zeros.
module hex_scan_display #(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input logic              clk,
  input logic              rst_n,
  hex_scan_display_if.slave bus
);

  localparam int             CW        = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0]  BLANK_CNT = CW'(BLANK);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;
  logic [0:0]    state_d;
  logic          wrap;
  logic          dark;
  logic [3:0]    nib;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  // Output flops are loaded from next-state values so they line up with the
  // counter registers in the same cycle, while i_blank lands one cycle late.
  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    wrap     = (cnt_q == CNT_MAX) && (idx_q == 2'd3);
    cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d    = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
    shadow_d = bus.i_load ? bus.i_value : shadow_q;
    disp_d   = wrap ? shadow_d : disp_q;
    state_d  = (cnt_d < BLANK_CNT) ? ST_BLANK : ST_DRIVE;
    nib      = disp_d[{idx_d, 2'b00} +: 4];
    frame_d  = wrap;

`ifdef HEX_LZ_BLANK_EN
    case (idx_d)
      2'd3:    dark = (disp_d[15:12] == 4'h0);
      2'd2:    dark = (disp_d[15:8]  == 8'h00);
      2'd1:    dark = (disp_d[15:4]  == 12'h000);
      default: dark = 1'b0;
    endcase
`else
    dark = 1'b0;
`endif

    if (state_d == ST_BLANK || bus.i_blank || dark) begin
      anode_d = 4'hF;
      seg_d   = 7'h7F;
    end else begin
      anode_d = ~(4'b0001 << idx_d);
      seg_d   = decode(nib);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      disp_q   <= 16'h0000;
      anode_q  <= 4'hF;
      seg_q    <= 7'h7F;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.o_anode = anode_q;
  assign bus.o_seg   = seg_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed frame-by-frame bench for hex_scan_display with DIV=8, BLANK=2;
// expectations follow HEX_LZ_BLANK_EN when it is defined.
module tb_hex_scan_display;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

`ifdef HEX_LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  hex_scan_display_if bus ();

  hex_scan_display #(.DIV(8), .BLANK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered on the falling edge of cycle 0 of a frame; leaves on cycle 0 of the next.
  // bmask bit p = i_blank level seen by cycle p; lp/lv = load strobes issued in cycle p.
  task automatic run_frame(input string name,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic first, input logic [31:0] bmask,
                           input logic next_blank,
                           input int lp1, input logic [15:0] lv1,
                           input int lp2, input logic [15:0] lv2);
    logic [6:0] segs [4];
    segs = '{s0, s1, s2, s3};
    for (int p = 0; p < 32; p++) begin
      int slot;
      int c;
      logic [3:0] ea;
      logic [6:0] es;
      slot = p / 8;
      c    = p % 8;
      if (c < 2 || bmask[p] || segs[slot] == 7'h7F) begin
        ea = 4'hF;
        es = 7'h7F;
      end else begin
        ea = ~(4'b0001 << slot);
        es = segs[slot];
      end
      check($sformatf("%s p%0d anode", name, p), {12'h0, bus.o_anode}, {12'h0, ea});
      check($sformatf("%s p%0d seg", name, p), {9'h0, bus.o_seg}, {9'h0, es});
      check($sformatf("%s p%0d frame", name, p), {15'h0, bus.o_frame},
            {15'h0, (p == 0) && !first});
      bus.i_load = (p == lp1) || (p == lp2);
      if (p == lp2)      bus.i_value = lv2;
      else if (p == lp1) bus.i_value = lv1;
      bus.i_blank = (p == 31) ? next_blank : bmask[p+1];
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_value = 16'h0000;
    bus.i_load  = 1'b0;
    bus.i_blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst anode", {12'h0, bus.o_anode}, 16'h000F);
    check("rst seg", {9'h0, bus.o_seg}, 16'h007F);
    check("rst frame", {15'h0, bus.o_frame}, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset contents, then 0x1234 loaded mid-frame.
    run_frame("A", 7'h40, LZ, LZ, LZ, 1'b1, 32'h0, 1'b0, 10, 16'h1234, -1, 16'h0);
    // 0x1234 shown; 0xABCD loaded during digit 2 must not tear this frame.
    run_frame("B", 7'h19, 7'h30, 7'h24, 7'h79, 1'b0, 32'h0, 1'b0, 17, 16'hABCD, -1, 16'h0);
    // 0xABCD shown; 0xF00F loaded exactly on the wrap edge.
    run_frame("C", 7'h21, 7'h46, 7'h03, 7'h08, 1'b0, 32'h0, 1'b0, 31, 16'hF00F, -1, 16'h0);
    // 0xF00F shown; two loads, the later 0x0007 must win; blank armed for next frame.
    run_frame("D", 7'h0E, 7'h40, 7'h40, 7'h0E, 1'b0, 32'h0, 1'b1, 5, 16'h5555, 20, 16'h0007);
    // Whole frame blanked, frame pulse still expected at p0.
    run_frame("E", 7'h78, LZ, LZ, LZ, 1'b0, 32'hFFFF_FFFF, 1'b1, -1, 16'h0, -1, 16'h0);
    // Blank released after cycle 3; drive returns at cycle 4. Then load 0x0000.
    run_frame("F", 7'h78, LZ, LZ, LZ, 1'b0, 32'h0000_000F, 1'b0, 3, 16'h0000, -1, 16'h0);
    run_frame("G", 7'h40, LZ, LZ, LZ, 1'b0, 32'h0, 1'b0, -1, 16'h0, -1, 16'h0);

    // Load 0xBEEF into the shadow, then reset in the middle of digit 1's drive.
    bus.i_load  = 1'b1;
    bus.i_value = 16'hBEEF;
    @(negedge clk);
    bus.i_load  = 1'b0;
    repeat (12) @(negedge clk);
    check("H pre-rst anode", {12'h0, bus.o_anode}, (LZ == 7'h7F) ? 16'h000F : 16'h000D);
    check("H pre-rst seg", {9'h0, bus.o_seg}, {9'h0, LZ});
    #1 rst_n = 1'b0;
    #1;
    check("mid rst anode", {12'h0, bus.o_anode}, 16'h000F);
    check("mid rst seg", {9'h0, bus.o_seg}, 16'h007F);
    check("mid rst frame", {15'h0, bus.o_frame}, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_frame("I", 7'h40, LZ, LZ, LZ, 1'b1, 32'h0, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame("J", 7'h40, LZ, LZ, LZ, 1'b0, 32'h0, 1'b0, -1, 16'h0, -1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
